axis_beat_serializer: RTL and testbench

Synthesizable AXI-Stream downsizer. Its slave port accepts wide multi-word beats from a bus-width stream, carrying TKEEP and TLAST. Its master port emits one word per beat on a word-width stream. It sits downstream of bus-width producers, such as DMA read paths or file-driven stream sources, and feeds word-serial consumers like the systolic array input ports. It drops lanes whose keep bit is 0 and propagates packet boundaries.

---
 rtl/axis_beat_serializer.sv | 87 ++++++++
 tb/tb_axis_beat_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_beat_serializer.sv
// AXI-Stream downsizer: splits wide multi-lane beats into one word per master beat,
// skipping lanes whose keep bit is clear and carrying TLAST onto the final kept word.
module axis_beat_serializer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned BUS_WIDTH  = 64,
    localparam int unsigned WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    output logic                      s_ready,
    input  logic                      s_valid,
    input  logic                      s_last,
    input  logic [BUS_WIDTH-1:0]      s_data,
    input  logic [WORDS_PER_BEAT-1:0] s_keep,
    input  logic                      m_ready,
    output logic                      m_valid,
    output logic                      m_last,
    output logic [WORD_WIDTH-1:0]     m_data,
    output logic                      drop_last
);

    localparam int unsigned LaneW = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
    localparam logic [WORDS_PER_BEAT-1:0] RemOne = WORDS_PER_BEAT'(1);

    typedef logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] lanes_t;

    lanes_t                    buf_data_q, buf_data_d;
    logic                      buf_last_q, buf_last_d;
    logic [WORDS_PER_BEAT-1:0] rem_q, rem_d;
    logic                      drop_last_q, drop_last_d;
    logic [LaneW-1:0]          cur;
    logic                      rem_one;
    logic                      s_hs;
    logic                      m_hs;

    // Priority encoder: lowest pending lane is emitted first.
    always_comb begin
        cur = '0;
        for (int i = int'(WORDS_PER_BEAT) - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                cur = LaneW'(i);
            end
        end
    end

    assign rem_one   = (rem_q != '0) && ((rem_q & (rem_q - RemOne)) == '0);
    assign m_valid   = (rem_q != '0);
    assign m_data    = buf_data_q[cur];
    assign m_last    = buf_last_q & rem_one;
    // Accept a new beat on the same edge the final pending word leaves.
    assign s_ready   = aresetn & (~m_valid | (m_ready & rem_one));
    assign drop_last = drop_last_q;
    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;

    always_comb begin
        rem_d       = rem_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        drop_last_d = 1'b0;
        if (m_hs) begin
            rem_d[cur] = 1'b0;
        end
        // A new beat overrides the clear of the last pending lane.
        if (s_hs) begin
            rem_d       = s_keep;
            buf_data_d  = s_data;
            buf_last_d  = s_last;
            drop_last_d = s_last & (s_keep == '0);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q       <= '0;
            buf_data_q  <= '0;
            buf_last_q  <= 1'b0;
            drop_last_q <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            drop_last_q <= drop_last_d;
        end
    end

endmodule

// File: tb/tb_axis_beat_serializer.sv
// Directed and randomized-handshake bench for axis_beat_serializer (16-bit words, 4 lanes).
module tb_axis_beat_serializer;

    logic        aclk;
    logic        aresetn;
    logic        s_ready;
    logic        s_valid;
    logic        s_last;
    logic [63:0] s_data;
    logic [3:0]  s_keep;
    logic        m_ready;
    logic        m_valid;
    logic        m_last;
    logic [15:0] m_data;
    logic        drop_last;

    int n_checks;
    int n_pass;

    axis_beat_serializer #(
        .WORD_WIDTH(16),
        .BUS_WIDTH (64)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_ready  (s_ready),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_data   (s_data),
        .s_keep   (s_keep),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_data   (m_data),
        .drop_last(drop_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_data  = 64'hdead_beef_cafe_f00d;
        s_keep  = 4'b1111;
        s_last  = 1'b1;
    endtask

    function automatic logic exp_last(input int k);
        return (k == 201) || (k % 20 == 19);
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        aresetn  = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data   = '0;
        s_keep   = '0;
        m_ready  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_drop_last", 32'(drop_last), 32'd0);
        check("rst_s_ready_low", 32'(s_ready), 32'd0);
        aresetn = 1'b1;
        #1;
        check("rst_s_ready_released", 32'(s_ready), 32'd1);

        // 1: single full beat
        m_ready = 1'b1;
        send_beat(64'h0003_0002_0001_0000, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t1_m_valid", 32'(m_valid), 32'd1);
            check("t1_m_data", 32'(m_data), 32'(i));
            check("t1_m_last", 32'(m_last), 32'(i == 3));
            check("t1_s_ready", 32'(s_ready), 32'(i == 3));
            tick();
        end
        check("t1_drained", 32'(m_valid), 32'd0);

        // 2: back-to-back beats, second accepted alongside the last word of the first
        s_valid = 1'b1;
        s_data  = 64'h0003_0002_0001_0000;
        s_keep  = 4'b1111;
        s_last  = 1'b0;
        tick();
        s_data = 64'h0007_0006_0005_0004;
        s_last = 1'b1;
        for (int w = 0; w < 8; w++) begin
            check("t2_m_valid", 32'(m_valid), 32'd1);
            check("t2_m_data", 32'(m_data), 32'(w));
            check("t2_m_last", 32'(m_last), 32'(w == 7));
            if (w == 3) check("t2_s_ready_overlap", 32'(s_ready), 32'd1);
            tick();
            if (w == 3) s_valid = 1'b0;
        end
        check("t2_drained", 32'(m_valid), 32'd0);

        // 3: partial last beat
        send_beat(64'h0023_0022_0021_0020, 4'b0011, 1'b1);
        check("t3_w0", 32'(m_data), 32'h20);
        check("t3_w0_last", 32'(m_last), 32'd0);
        tick();
        check("t3_w1", 32'(m_data), 32'h21);
        check("t3_w1_last", 32'(m_last), 32'd1);
        tick();
        check("t3_empty", 32'(m_valid), 32'd0);
        check("t3_s_ready", 32'(s_ready), 32'd1);

        // 4: sparse keep
        send_beat(64'h000d_000c_000b_000a, 4'b1010, 1'b1);
        check("t4_w0", 32'(m_data), 32'h0b);
        check("t4_w0_last", 32'(m_last), 32'd0);
        tick();
        check("t4_w1", 32'(m_data), 32'h0d);
        check("t4_w1_last", 32'(m_last), 32'd1);
        tick();
        check("t4_empty", 32'(m_valid), 32'd0);

        // 5: backpressure with garbage on an idle slave port, then async reset
        send_beat(64'h0033_0032_0031_0030, 4'b1111, 1'b1);
        check("t5_w0", 32'(m_data), 32'h30);
        tick();
        m_ready = 1'b0;
        s_keep  = 4'b0101;
        s_data  = 64'h1111_2222_3333_4444;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("t5_hold_valid", 32'(m_valid), 32'd1);
            check("t5_hold_data", 32'(m_data), 32'h31);
            check("t5_hold_last", 32'(m_last), 32'd0);
            check("t5_hold_s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        aresetn = 1'b0;
        #1;
        check("t5_rst_m_valid", 32'(m_valid), 32'd0);
        check("t5_rst_s_ready", 32'(s_ready), 32'd0);
        #1;
        aresetn = 1'b1;
        m_ready = 1'b1;
        send_beat(64'h0043_0042_0041_0040, 4'b1100, 1'b1);
        check("t5_restart_w0", 32'(m_data), 32'h42);
        check("t5_restart_w0_last", 32'(m_last), 32'd0);
        tick();
        check("t5_restart_w1", 32'(m_data), 32'h43);
        check("t5_restart_w1_last", 32'(m_last), 32'd1);
        tick();
        check("t5_restart_empty", 32'(m_valid), 32'd0);

        // 6a: empty-keep beats
        check("t6_drop_idle", 32'(drop_last), 32'd0);
        send_beat(64'h0053_0052_0051_0050, 4'b0000, 1'b1);
        check("t6_drop_pulse", 32'(drop_last), 32'd1);
        check("t6_drop_no_valid", 32'(m_valid), 32'd0);
        tick();
        check("t6_drop_cleared", 32'(drop_last), 32'd0);
        send_beat(64'h0063_0062_0061_0060, 4'b0000, 1'b0);
        check("t6_nolast_no_drop", 32'(drop_last), 32'd0);
        check("t6_nolast_no_valid", 32'(m_valid), 32'd0);
        tick();

        // 6b: random-handshake stress, 202 words in 11 packets
        begin
            int  got;
            int  lasts;
            int  errs;
            bit  prod_timeout;
            got          = 0;
            lasts        = 0;
            errs         = 0;
            prod_timeout = 1'b0;
            fork
                begin
                    int guard;
                    guard = 0;
                    for (int b = 0; b < 51; b++) begin
                        logic [63:0] d;
                        logic        hs;
                        for (int l = 0; l < 4; l++) d[l*16 +: 16] = 16'(4 * b + l);
                        while ($urandom_range(99) >= 5 && guard < 30000) begin
                            tick();
                            guard++;
                        end
                        s_valid = 1'b1;
                        s_data  = d;
                        s_keep  = (b == 50) ? 4'b0011 : 4'b1111;
                        s_last  = (b % 5 == 4) || (b == 50);
                        do begin
                            @(negedge aclk);
                            hs = s_ready;
                            tick();
                            guard++;
                        end while (!hs && guard < 30000);
                        if (!hs) prod_timeout = 1'b1;
                        s_valid = 1'b0;
                        s_data  = {$urandom, $urandom};
                        s_keep  = 4'($urandom);
                        s_last  = 1'($urandom);
                    end
                end
                begin
                    int cyc;
                    cyc = 0;
                    while (got < 202 && cyc < 30000) begin
                        m_ready = ($urandom_range(99) < 20);
                        @(negedge aclk);
                        if (m_valid && m_ready) begin
                            if (m_data != 16'(got)) errs++;
                            if (m_last != exp_last(got)) errs++;
                            if (m_last) lasts++;
                            got++;
                        end
                        tick();
                        cyc++;
                    end
                    m_ready = 1'b1;
                end
            join
            check("t6_prod_timeout", 32'(prod_timeout), 32'd0);
            check("t6_word_count", 32'(got), 32'd202);
            check("t6_order_errors", 32'(errs), 32'd0);
            check("t6_last_count", 32'(lasts), 32'd11);
            repeat (4) tick();
            check("t6_no_extra_words", 32'(m_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
